// File: rtl/la_capture.sv
// -----------------------------------------------------------------------------
// la_capture -- logic-analyser capture engine streaming samples into a pair of
// SQI serial SRAMs (one nibble-wide chip per 4 sample bits).
//
// Sequence: IDLE -> CMD (write opcode 0x02, 2 nibbles) -> ADDR (0x000000,
// 6 nibbles) -> [ARM: wait for trigger] -> CAPTURE (samples_post+1 samples)
// -> DONE. Command and address nibbles are duplicated on every chip.
//
// Configuration macro: LA_TRIGGER_EN
//   defined   : ARM state and the masked trigger compare are built.
//   undefined : ADDR goes straight to CAPTURE; trig_mask/trig_value ignored.
//
// Ports
//   clock         sole clock; SRAM SCK = clock & sram_clk_en
//   reset_n       asynchronous active-low reset
//   start         single-cycle capture request (accepted in IDLE/DONE only)
//   samples_post  post-trigger sample count minus one, latched on start
//   trig_mask     bits taking part in the trigger compare
//   trig_value    required level of each masked bit
//   lat           sample data from the input latches
//   sram_cs_n     shared SRAM chip select, active-low
//   sram_clk_en   SCK gate
//   sram_oe       SIO output enable
//   sram_dout     SIO drive data; [3:0] chip 0, [7:4] chip 1, ...
//   busy          high in every state except IDLE and DONE
//   done          capture complete, held until the next accepted start
//   sample_count  samples written, saturating
// All outputs are registered.
// -----------------------------------------------------------------------------
module la_capture #(
  parameter int LA_WIDTH    = 8,   // must be a multiple of 4 (one nibble per chip)
  parameter int COUNT_WIDTH = 23
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] samples_post,
  input  logic [LA_WIDTH-1:0]    trig_mask,
  input  logic [LA_WIDTH-1:0]    trig_value,
  input  logic [LA_WIDTH-1:0]    lat,
  output logic                   sram_cs_n,
  output logic                   sram_clk_en,
  output logic                   sram_oe,
  output logic [LA_WIDTH-1:0]    sram_dout,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] sample_count
);

  localparam int              CHIPS      = LA_WIDTH / 4;
  localparam logic [7:0]      SQI_WRITE  = 8'h02;
  localparam logic [23:0]     START_ADDR = 24'h000000;
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
`ifdef LA_TRIGGER_EN
    S_ARM,
`endif
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [2:0]             nib_q, nib_d;     // nibble index within CMD / ADDR
  logic [COUNT_WIDTH-1:0] cap_q, cap_d;     // capture index, compared to post_q
  logic [COUNT_WIDTH-1:0] post_q, post_d;   // samples_post latched at start
  logic [COUNT_WIDTH-1:0] count_d;

  logic                   cs_n_d, clk_en_d, oe_d, busy_d, done_d;
  logic [LA_WIDTH-1:0]    dout_d;
  logic [7:0]             op_shift;
  logic [23:0]            addr_shift;

`ifdef LA_TRIGGER_EN
  logic trig_hit;
  assign trig_hit = ((lat ^ trig_value) & trig_mask) == '0;
`else
  logic unused_trig;
  assign unused_trig = ^{trig_mask, trig_value};
`endif

  // Next-state logic plus output lookahead: outputs are decoded from the
  // next state so that they can be registered without a cycle of lag.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
    state_d    = state_q;
    nib_d      = nib_q;
    cap_d      = cap_q;
    post_d     = post_q;
    count_d    = sample_count;
    cs_n_d     = 1'b1;
    clk_en_d   = 1'b0;
    oe_d       = 1'b0;
    dout_d     = '0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    op_shift   = 8'h00;
    addr_shift = 24'h000000;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_CMD;
          nib_d   = 3'd0;
          cap_d   = '0;
          post_d  = samples_post;
          count_d = '0;
        end
      end
      S_CMD: begin
        if (nib_q == 3'd1) begin
          state_d = S_ADDR;
          nib_d   = 3'd0;
        end else begin
          nib_d = nib_q + 3'd1;
        end
      end
      S_ADDR: begin
        if (nib_q == 3'd5) begin
          nib_d = 3'd0;
`ifdef LA_TRIGGER_EN
          state_d = S_ARM;
`else
          state_d = S_CAPTURE;
`endif
        end else begin
          nib_d = nib_q + 3'd1;
        end
      end
`ifdef LA_TRIGGER_EN
      S_ARM: begin
        if (trig_hit) state_d = S_CAPTURE;
      end
`endif
      S_CAPTURE: begin
        if (sample_count != COUNT_MAX) count_d = sample_count + COUNT_WIDTH'(1);
        if (cap_q == post_q) state_d = S_DONE;
        else                 cap_d   = cap_q + COUNT_WIDTH'(1);
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_CMD: begin
        // High nibble of the opcode goes out first.
        op_shift = SQI_WRITE << {nib_d[0], 2'b00};
        cs_n_d   = 1'b0;
        clk_en_d = 1'b1;
        oe_d     = 1'b1;
        dout_d   = {CHIPS{op_shift[7:4]}};
        busy_d   = 1'b1;
      end
      S_ADDR: begin
        addr_shift = START_ADDR << {nib_d, 2'b00};
        cs_n_d     = 1'b0;
        clk_en_d   = 1'b1;
        oe_d       = 1'b1;
        dout_d     = {CHIPS{addr_shift[23:20]}};
        busy_d     = 1'b1;
      end
`ifdef LA_TRIGGER_EN
      S_ARM: begin
        // SRAM stays selected but unclocked while waiting for the trigger.
        cs_n_d = 1'b0;
        oe_d   = 1'b1;
        busy_d = 1'b1;
      end
`endif
      S_CAPTURE: begin
        // The dout register is the one-cycle pipeline stage: the first
        // sample written is lat from the cycle that entered CAPTURE.
        cs_n_d   = 1'b0;
        clk_en_d = 1'b1;
        oe_d     = 1'b1;
        dout_d   = lat;
        busy_d   = 1'b1;
      end
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      nib_q        <= 3'd0;
      cap_q        <= '0;
      post_q       <= '0;
      sample_count <= '0;
      sram_cs_n    <= 1'b1;
      sram_clk_en  <= 1'b0;
      sram_oe      <= 1'b0;
      sram_dout    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q      <= state_d;
      nib_q        <= nib_d;
      cap_q        <= cap_d;
      post_q       <= post_d;
      sample_count <= count_d;
      sram_cs_n    <= cs_n_d;
      sram_clk_en  <= clk_en_d;
      sram_oe      <= oe_d;
      sram_dout    <= dout_d;
      busy         <= busy_d;
      done         <= done_d;
    end
  end

endmodule

// File: tb/tb_la_capture.sv
// -----------------------------------------------------------------------------
// tb_la_capture -- self-checking bench for la_capture.
// A vector table covers the basic capture sequence (with start pulses that
// must be ignored); hand-written sequences cover trigger wait / no-trigger
// build, asynchronous reset mid-capture, samples_post latching and count
// saturation (on a second instance with a 3-bit counter).
// -----------------------------------------------------------------------------
module tb_la_capture;

  localparam int LW = 8;
  localparam int CW = 23;
`ifdef LA_TRIGGER_EN
  localparam int ARM_CYC = 1;
`else
  localparam int ARM_CYC = 0;
`endif

  logic          clock = 1'b0;
  logic          reset_n;
  logic          start;
  logic [CW-1:0] samples_post;
  logic [LW-1:0] trig_mask, trig_value, lat;
  logic          sram_cs_n, sram_clk_en, sram_oe, busy, done;
  logic [LW-1:0] sram_dout;
  logic [CW-1:0] sample_count;

  logic          start2;
  logic [2:0]    post2;
  logic          cs_n2, clk_en2, oe2, busy2, done2;
  logic [LW-1:0] dout2;
  logic [2:0]    count2;

  la_capture #(.LA_WIDTH(LW), .COUNT_WIDTH(CW)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .samples_post(samples_post),
    .trig_mask(trig_mask), .trig_value(trig_value), .lat(lat),
    .sram_cs_n(sram_cs_n), .sram_clk_en(sram_clk_en), .sram_oe(sram_oe),
    .sram_dout(sram_dout), .busy(busy), .done(done), .sample_count(sample_count)
  );

  la_capture #(.LA_WIDTH(LW), .COUNT_WIDTH(3)) dut_sat (
    .clock(clock), .reset_n(reset_n), .start(start2), .samples_post(post2),
    .trig_mask(trig_mask), .trig_value(trig_value), .lat(lat),
    .sram_cs_n(cs_n2), .sram_clk_en(clk_en2), .sram_oe(oe2),
    .sram_dout(dout2), .busy(busy2), .done(done2), .sample_count(count2)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic          start;
    logic [CW-1:0] post;
    logic [LW-1:0] lat;
    logic          cs_n, clk_en, oe;
    logic [LW-1:0] dout;
    logic          busy, done;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic cs_n, input logic clk_en,
                            input logic oe, input logic [LW-1:0] dout, input logic bsy,
                            input logic dn, input logic [CW-1:0] cnt);
    check({tag, ".cs_n"},   32'(sram_cs_n),    32'(cs_n));
    check({tag, ".clk_en"}, 32'(sram_clk_en),  32'(clk_en));
    check({tag, ".oe"},     32'(sram_oe),      32'(oe));
    check({tag, ".dout"},   32'(sram_dout),    32'(dout));
    check({tag, ".busy"},   32'(busy),         32'(bsy));
    check({tag, ".done"},   32'(done),         32'(dn));
    check({tag, ".count"},  32'(sample_count), 32'(cnt));
  endtask

  // Each vector: outputs expected at this negedge, then inputs driven for the
  // following rising edge. lat is a distinct value per vector so that a
  // captured sample identifies the cycle it came from.
  function automatic void add_vec(logic st, logic [CW-1:0] post, logic cs_n, logic ck,
                                  logic oe, logic [LW-1:0] dout, logic bsy, logic dn,
                                  logic [CW-1:0] cnt);
    vec_t v;
    v.start = st;  v.post = post;  v.lat = 8'h30 + 8'(vecs.size());
    v.cs_n = cs_n; v.clk_en = ck;  v.oe = oe; v.dout = dout;
    v.busy = bsy;  v.done = dn;    v.cnt = cnt;
    vecs.push_back(v);
  endfunction

  function automatic void add_cap(logic st, int k);
    // Captured data is the lat value driven one vector earlier.
    add_vec(st, '0, 1'b0, 1'b1, 1'b1, 8'h30 + 8'(vecs.size() - 1), 1'b1, 1'b0, CW'(k));
  endfunction

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ck;
    reset_n = 1'b0; start = 1'b0; start2 = 1'b0; post2 = 3'd0;
    samples_post = '0; trig_mask = 8'h00; trig_value = 8'hFF; lat = 8'h00;

    // Reset values while reset_n is held low across clock edges.
    #12;
    check_outs("reset_hold", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, '0);
    @(negedge clock) reset_n = 1'b1;

    // ---- Vector table: samples_post=3, trig_mask=0, ignored start pulses ----
    add_vec(1'b1, CW'(3), 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, '0);  // IDLE, start
    add_vec(1'b0, '0,     1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, '0);  // CMD nibble 0x0
    add_vec(1'b0, '0,     1'b0, 1'b1, 1'b1, 8'h22, 1'b1, 1'b0, '0);  // CMD nibble 0x2
    for (int a = 0; a < 6; a++)                                       // ADDR, start at a=2
      add_vec(a == 2, '0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, '0);
`ifdef LA_TRIGGER_EN
    add_vec(1'b0, '0,     1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, '0);  // ARM, hits at once
`endif
    for (int k = 0; k < 4; k++) add_cap(1'b1, k);                     // start ignored, incl. last
    add_vec(1'b0, '0,     1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, CW'(4)); // DONE
    add_vec(1'b0, '0,     1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, CW'(4)); // DONE held

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      check_outs($sformatf("vec%0d", i), vecs[i].cs_n, vecs[i].clk_en, vecs[i].oe,
                 vecs[i].dout, vecs[i].busy, vecs[i].done, vecs[i].cnt);
      start        = vecs[i].start;
      samples_post = vecs[i].post;
      lat          = vecs[i].lat;
    end

    // ---- Trigger wait (trigger build) / no ARM stage (default build) ----
`ifdef LA_TRIGGER_EN
    trig_mask = 8'h01; trig_value = 8'h01; lat = 8'h00;
`else
    trig_mask = 8'hFF; trig_value = 8'hAA; lat = 8'h00;
`endif
    @(negedge clock) begin start = 1'b1; samples_post = '0; end   // restart from DONE
    @(negedge clock) start = 1'b0;
    check("restart.done", 32'(done), 32'd0);
    check("restart.count", 32'(sample_count), 32'd0);
    check("restart.cmd0", 32'(sram_dout), 32'h00);
    repeat (7) @(negedge clock);                                   // last ADDR cycle
`ifdef LA_TRIGGER_EN
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check($sformatf("arm%0d.clk_en", i), 32'(sram_clk_en), 32'd0);
      check($sformatf("arm%0d.cs_n", i), 32'(sram_cs_n), 32'd0);
    end
    @(negedge clock);
    check("arm_last.clk_en", 32'(sram_clk_en), 32'd0);
    lat = 8'h01;
    @(negedge clock);
    lat = 8'h55;
    check("trig_cap.dout", 32'(sram_dout), 32'h01);
    check("trig_cap.clk_en", 32'(sram_clk_en), 32'd1);
`else
    @(negedge clock);
    check("notrig_cap.clk_en", 32'(sram_clk_en), 32'd1);
    check("notrig_cap.cs_n", 32'(sram_cs_n), 32'd0);
    check("notrig_cap.count", 32'(sample_count), 32'd0);
`endif
    @(negedge clock);
    check("single.done", 32'(done), 32'd1);
    check("single.count", 32'(sample_count), 32'd1);

    // ---- Asynchronous reset at sample 2 of 8 ----
    trig_mask = 8'h00; lat = 8'h5A;
    @(negedge clock) begin start = 1'b1; samples_post = CW'(7); end
    @(negedge clock) start = 1'b0;
    repeat (10 + ARM_CYC) @(negedge clock);
    check("pre_reset.count", 32'(sample_count), 32'd2);
    check("pre_reset.clk_en", 32'(sram_clk_en), 32'd1);
    #2 reset_n = 1'b0;
    #1 check_outs("async_reset", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, '0);
    @(negedge clock) reset_n = 1'b1;
    repeat (3) @(negedge clock);
    check_outs("post_reset_idle", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, '0);

    // ---- samples_post changed mid-capture 7 -> 1: still 8 samples ----
    @(negedge clock) begin start = 1'b1; samples_post = CW'(7); end
    @(negedge clock) begin start = 1'b0; samples_post = CW'(1); end
    ck = 0;
    for (int i = 0; i < 60 && done !== 1'b1; i++) begin
      if (sram_clk_en === 1'b1) ck++;
      @(negedge clock);
    end
    check("latch_post.done", 32'(done), 32'd1);
    check("latch_post.count", 32'(sample_count), 32'd8);
    check("latch_post.sck_cycles", 32'(ck), 32'd16);   // 8 CMD/ADDR + 8 samples

    // ---- Saturation on the 3-bit instance: 8 samples, count stops at 7 ----
    @(negedge clock) begin start2 = 1'b1; post2 = 3'd7; end
    @(negedge clock) start2 = 1'b0;
    for (int i = 0; i < 60 && done2 !== 1'b1; i++) @(negedge clock);
    check("sat.done", 32'(done2), 32'd1);
    check("sat.count", 32'(count2), 32'd7);
    check("sat.busy", 32'(busy2), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
